riscv_dmem_axi_bridge: RTL and testbench
========================================

Name: riscv_dmem_axi_bridge

Overview:
Data-side memory bridge directly downstream of the load/store unit. It accepts one LSU request at a time (load, store or cache-maintenance op) and converts it into AXI4-Lite read or write transactions. It returns a single ack/error response per request, with tag and read data, to the LSU response interface. There is no cache, so cache-maintenance ops complete locally.

Parameters:
TIMEOUT_CYCLES, 1024, cycles to wait for R/B response before a bus-error ack; 0 disables the timeout
TIMEOUT_W, 16, timeout counter width; requires TIMEOUT_CYCLES < 2**TIMEOUT_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
mem_addr  in  32  request address (word aligned by LSU)
mem_wdata  in  32  store data, lane-steered
mem_rd  in  1  load request
mem_wr  in  4  store byte enables
mem_cacheable  in  1  ignored (no cache)
mem_req_tag  in  11  request tag
mem_invalidate  in  1  cache invalidate op
mem_writeback  in  1  cache writeback op
mem_flush  in  1  cache flush op
mem_accept  out  1  request taken this cycle
mem_ack  out  1  response valid (one-cycle pulse)
mem_error  out  1  response is an error; qualified by mem_ack
mem_rdata  out  32  load data; qualified by mem_ack
mem_resp_tag  out  11  tag of the completing request
mem_load_fault  out  1  always 0 (no MMU)
mem_store_fault  out  1  always 0
axi_awvalid/awready  out/in  1  write address handshake
axi_awaddr  out  32  write address
axi_wvalid/wready  out/in  1  write data handshake
axi_wdata  out  32  write data
axi_wstrb  out  4  write strobes
axi_bvalid/bready  in/out  1  write response handshake
axi_bresp  in  2  write response
axi_arvalid/arready  out/in  1  read address handshake
axi_araddr  out  32  read address
axi_rvalid/rready  in/out  1  read data handshake
axi_rdata  in  32  read data
axi_rresp  in  2  read response

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, CMO, DRAIN. Reset: IDLE; all outputs 0; counters and flags 0.
- mem_accept = (state==IDLE), combinational. A request is taken when mem_accept is 1 and any of rd, |wr, invalidate, writeback or flush is 1.
- On take: latch addr, wdata, wr, tag. Priority when several request bits are set: rd > wr > cache op.
  - rd: go to RD_ADDR.
  - wr: go to WR_REQ.
  - cache op: go to CMO.
- Addresses: axi_araddr and axi_awaddr = {addr[31:2],2'b00}.
- RD_ADDR: arvalid=1 from the registered address. On arready go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - register rdata;
  - error = (rresp != 0);
  - ack_q=1;
  - go to IDLE.
- WR_REQ: awvalid = !aw_done and wvalid = !w_done, each handshaking independently. aw_done and w_done are sticky. When both are done (including the same cycle) go to WR_RESP.
- WR_RESP: bready=1. On bvalid: error = (bresp != 0), ack_q=1, go to IDLE.
- CMO: ack_q=1 with error=0, go to IDLE. No bus traffic.
- Response timing:
  - mem_ack is registered: it asserts the cycle after the R/B handshake or CMO entry, for exactly one cycle.
  - mem_rdata, mem_error and mem_resp_tag are valid with mem_ack.
  - mem_rdata = 0 for stores, CMOs and errors.
  - mem_accept is already 1 during the ack cycle, so back-to-back requests are allowed.
  - Minimum latency with arready and rvalid immediate: load ack 3 cycles after take. CMO ack 2 cycles after take.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter clears on take and increments in RD_DATA and WR_RESP.
  - When it reaches TIMEOUT_CYCLES: ack_q=1, error=1, go to DRAIN.
  - DRAIN: rready=bready=1, mem_accept=0. Leave to IDLE on the stale rvalid/bvalid, with no ack.
- rready and bready are 0 in every state except RD_DATA, WR_RESP and DRAIN. No AXI valid is ever dropped before its ready.
- Reset mid-transaction: return to IDLE immediately, all AXI valids drop, pending ack lost.

Test Plan:
- Load addr 0x80000104, tag 0x155; arready and rvalid each 1 cycle later, rdata 0xDEADBEEF, rresp 0 -> araddr 0x80000104; mem_ack one cycle after R handshake, rdata 0xDEADBEEF, tag 0x155, error 0.
- Store addr 0x80000002, wr 4'b1100, wdata 0xABCD0000; wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held; single ack after bvalid, error 0.
- Load with rresp=2'b10 -> mem_ack=1, mem_error=1, mem_rdata=0, mem_load_fault=0.
- Flush op, tag 0x7 -> no axi valids; ack 2 cycles after take, error 0, tag 0x7.
- TIMEOUT_CYCLES=8; load with rvalid withheld -> error ack after 8 RD_DATA cycles; mem_accept=0 until a late rvalid, which is consumed with no ack; then mem_accept=1.
- rst_n pulsed while in WR_REQ with awvalid=1 -> awvalid, wvalid and mem_ack go to 0 asynchronously; state IDLE, mem_accept=1 after release.

Source files
------------

// File: rtl/riscv_dmem_axi_bridge_if.sv
// LSU request/response and AXI4-Lite signals of the data-memory bridge.
// master is the bridge view; slave is the LSU/memory environment view.
interface riscv_dmem_axi_bridge_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic [3:0]  mem_wr;
  logic        mem_cacheable;
  logic [10:0] mem_req_tag;
  logic        mem_invalidate;
  logic        mem_writeback;
  logic        mem_flush;
  logic        mem_accept;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic [10:0] mem_resp_tag;
  logic        mem_load_fault;
  logic        mem_store_fault;

  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  modport master (
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_cacheable, mem_req_tag,
           mem_invalidate, mem_writeback, mem_flush,
    output mem_accept, mem_ack, mem_error, mem_rdata, mem_resp_tag,
           mem_load_fault, mem_store_fault,
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
           axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp,
           axi_arready, axi_rvalid, axi_rdata, axi_rresp
  );

  modport slave (
    output mem_addr, mem_wdata, mem_rd, mem_wr, mem_cacheable, mem_req_tag,
           mem_invalidate, mem_writeback, mem_flush,
    input  mem_accept, mem_ack, mem_error, mem_rdata, mem_resp_tag,
           mem_load_fault, mem_store_fault,
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
           axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp,
           axi_arready, axi_rvalid, axi_rdata, axi_rresp
  );
endinterface

// File: rtl/riscv_dmem_axi_bridge.sv
// Single-outstanding LSU-to-AXI4-Lite data bridge; cache ops complete locally.
//   state     | meaning
//   IDLE      | accepting a request
//   RD_ADDR   | AR valid, waiting arready
//   RD_DATA   | waiting R beat (timeout armed)
//   WR_REQ    | AW and W handshaking independently
//   WR_RESP   | waiting B beat (timeout armed)
//   CMO       | cache op, acked locally
//   DRAIN     | timed out; swallowing the late R/B beat without ack
module riscv_dmem_axi_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_dmem_axi_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_CMO, S_DRAIN
  } state_t;

  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [31:2]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [10:0]          r_tag;
  logic                 r_arvalid;
  logic                 r_awvalid;
  logic                 r_wvalid;
  logic                 r_rready;
  logic                 r_bready;
  logic                 r_ack;
  logic                 r_error;
  logic [31:0]          r_rdata;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;

  logic w_accept;
  logic w_cmo;
  logic w_take;
  logic w_tmo_hit;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused;

  assign w_accept  = (r_state == S_IDLE);
  assign w_cmo     = bus.mem_invalidate | bus.mem_writeback | bus.mem_flush;
  assign w_take    = w_accept & (bus.mem_rd | (|bus.mem_wr) | w_cmo);
  assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);
  // A channel counts as done once its valid has dropped or it handshakes now.
  assign w_aw_done = ~r_awvalid | bus.axi_awready;
  assign w_w_done  = ~r_wvalid  | bus.axi_wready;
  assign w_unused  = &{1'b0, bus.mem_cacheable, bus.mem_addr[1:0]};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_tag     <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rready  <= 1'b0;
      r_bready  <= 1'b0;
      r_ack     <= 1'b0;
      r_error   <= 1'b0;
      r_rdata   <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_addr    <= bus.mem_addr[31:2];
            r_wdata   <= bus.mem_wdata;
            r_wstrb   <= bus.mem_wr;
            r_tag     <= bus.mem_req_tag;
            r_tmo_cnt <= '0;
            if (bus.mem_rd) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end else if (|bus.mem_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_state   <= S_CMO;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.axi_rvalid) begin
            r_rready <= 1'b0;
            r_ack    <= 1'b1;
            r_error  <= |bus.axi_rresp;
            r_rdata  <= (bus.axi_rresp == 2'b00) ? bus.axi_rdata : 32'h0;
            r_state  <= S_IDLE;
          end else if (w_tmo_hit) begin
            r_ack    <= 1'b1;
            r_error  <= 1'b1;
            r_rdata  <= '0;
            r_rready <= 1'b1;
            r_bready <= 1'b1;
            r_state  <= S_DRAIN;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_WR_REQ: begin
          if (bus.axi_awready) r_awvalid <= 1'b0;
          if (bus.axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.axi_bvalid) begin
            r_bready <= 1'b0;
            r_ack    <= 1'b1;
            r_error  <= |bus.axi_bresp;
            r_rdata  <= '0;
            r_state  <= S_IDLE;
          end else if (w_tmo_hit) begin
            r_ack    <= 1'b1;
            r_error  <= 1'b1;
            r_rdata  <= '0;
            r_rready <= 1'b1;
            r_bready <= 1'b1;
            r_state  <= S_DRAIN;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_CMO: begin
          r_ack   <= 1'b1;
          r_error <= 1'b0;
          r_rdata <= '0;
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.axi_rvalid || bus.axi_bvalid) begin
            r_rready <= 1'b0;
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_accept      = w_accept;
  assign bus.mem_ack         = r_ack;
  assign bus.mem_error       = r_error;
  assign bus.mem_rdata       = r_rdata;
  assign bus.mem_resp_tag    = r_tag;
  assign bus.mem_load_fault  = 1'b0;
  assign bus.mem_store_fault = 1'b0;

  assign bus.axi_arvalid = r_arvalid;
  assign bus.axi_araddr  = {r_addr, 2'b00};
  assign bus.axi_rready  = r_rready;
  assign bus.axi_awvalid = r_awvalid;
  assign bus.axi_awaddr  = {r_addr, 2'b00};
  assign bus.axi_wvalid  = r_wvalid;
  assign bus.axi_wdata   = r_wdata;
  assign bus.axi_wstrb   = r_wstrb;
  assign bus.axi_bready  = r_bready;

endmodule

// File: tb/tb_riscv_dmem_axi_bridge.sv
// Directed bench for riscv_dmem_axi_bridge: loads, stores, cache ops,
// read error, response timeout with drain, and asynchronous reset.
module tb_riscv_dmem_axi_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  riscv_dmem_axi_bridge_if bus();

  riscv_dmem_axi_bridge #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_W     (16)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b1;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = '0;
    bus.mem_cacheable  = 1'b0;
    bus.mem_req_tag    = '0;
    bus.mem_invalidate = 1'b0;
    bus.mem_writeback  = 1'b0;
    bus.mem_flush      = 1'b0;
    bus.axi_awready    = 1'b0;
    bus.axi_wready     = 1'b0;
    bus.axi_bvalid     = 1'b0;
    bus.axi_bresp      = '0;
    bus.axi_arready    = 1'b0;
    bus.axi_rvalid     = 1'b0;
    bus.axi_rdata      = '0;
    bus.axi_rresp      = '0;

    // reset state
    repeat (3) tick();
    chk("rst_ack",     bus.mem_ack,     0);
    chk("rst_arvalid", bus.axi_arvalid, 0);
    chk("rst_awvalid", bus.axi_awvalid, 0);
    chk("rst_wvalid",  bus.axi_wvalid,  0);
    chk("rst_rready",  bus.axi_rready,  0);
    chk("rst_bready",  bus.axi_bready,  0);
    chk("rst_lfault",  bus.mem_load_fault, 0);
    rst_n = 1'b0;
    tick();
    chk("rst_accept", bus.mem_accept, 1);

    // load 0x80000104 tag 0x155
    bus.mem_rd      = 1'b1;
    bus.mem_addr    = 32'h8000_0104;
    bus.mem_req_tag = 11'h155;
    tick();
    bus.mem_rd = 1'b0;
    chk("ld_arvalid", bus.axi_arvalid, 1);
    chk("ld_araddr",  bus.axi_araddr,  32'h8000_0104);
    chk("ld_accept",  bus.mem_accept,  0);
    chk("ld_rready0", bus.axi_rready,  0);
    bus.axi_arready = 1'b1;
    tick();
    bus.axi_arready = 1'b0;
    chk("ld_arvalid_drop", bus.axi_arvalid, 0);
    chk("ld_rready",       bus.axi_rready,  1);
    chk("ld_ack_early",    bus.mem_ack,     0);
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = 32'hDEAD_BEEF;
    bus.axi_rresp  = 2'b00;
    tick();
    bus.axi_rvalid = 1'b0;
    chk("ld_ack",    bus.mem_ack,      1);
    chk("ld_rdata",  bus.mem_rdata,    32'hDEAD_BEEF);
    chk("ld_tag",    bus.mem_resp_tag, 11'h155);
    chk("ld_err",    bus.mem_error,    0);
    chk("ld_accept_ack", bus.mem_accept, 1);
    chk("ld_rready_off", bus.axi_rready, 0);
    tick();
    chk("ld_ack_pulse", bus.mem_ack, 0);

    // store 0x80000002, strobes 1100, W accepted 3 cycles before AW
    bus.mem_wr      = 4'b1100;
    bus.mem_addr    = 32'h8000_0002;
    bus.mem_wdata   = 32'hABCD_0000;
    bus.mem_req_tag = 11'h2AA;
    tick();
    bus.mem_wr = 4'b0000;
    chk("st_awvalid", bus.axi_awvalid, 1);
    chk("st_wvalid",  bus.axi_wvalid,  1);
    chk("st_awaddr",  bus.axi_awaddr,  32'h8000_0000);
    chk("st_wstrb",   bus.axi_wstrb,   4'b1100);
    chk("st_wdata",   bus.axi_wdata,   32'hABCD_0000);
    chk("st_arvalid", bus.axi_arvalid, 0);
    bus.axi_wready = 1'b1;
    tick();
    bus.axi_wready = 1'b0;
    chk("st_wvalid_drop", bus.axi_wvalid,  0);
    chk("st_aw_hold1",    bus.axi_awvalid, 1);
    tick();
    chk("st_aw_hold2",    bus.axi_awvalid, 1);
    chk("st_bready_off",  bus.axi_bready,  0);
    tick();
    chk("st_aw_hold3",    bus.axi_awvalid, 1);
    bus.axi_awready = 1'b1;
    tick();
    bus.axi_awready = 1'b0;
    chk("st_awvalid_drop", bus.axi_awvalid, 0);
    chk("st_bready",       bus.axi_bready,  1);
    chk("st_ack_early",    bus.mem_ack,     0);
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = 2'b00;
    tick();
    bus.axi_bvalid = 1'b0;
    chk("st_ack",   bus.mem_ack,      1);
    chk("st_err",   bus.mem_error,    0);
    chk("st_rdata", bus.mem_rdata,    0);
    chk("st_tag",   bus.mem_resp_tag, 11'h2AA);
    tick();
    chk("st_ack_single", bus.mem_ack, 0);

    // load with SLVERR; rd, wr and flush all set -> load wins
    bus.mem_rd      = 1'b1;
    bus.mem_wr      = 4'b1111;
    bus.mem_flush   = 1'b1;
    bus.mem_addr    = 32'h0000_0040;
    bus.mem_req_tag = 11'h011;
    tick();
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 4'b0000;
    bus.mem_flush = 1'b0;
    chk("pri_arvalid", bus.axi_arvalid, 1);
    chk("pri_awvalid", bus.axi_awvalid, 0);
    bus.axi_arready = 1'b1;
    tick();
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b1;
    bus.axi_rdata   = 32'h1234_5678;
    bus.axi_rresp   = 2'b10;
    tick();
    bus.axi_rvalid = 1'b0;
    bus.axi_rresp  = 2'b00;
    chk("lderr_ack",    bus.mem_ack,        1);
    chk("lderr_err",    bus.mem_error,      1);
    chk("lderr_rdata",  bus.mem_rdata,      0);
    chk("lderr_lfault", bus.mem_load_fault, 0);
    tick();

    // flush tag 0x7, then invalidate tag 0x3 issued in the ack cycle
    bus.mem_flush   = 1'b1;
    bus.mem_req_tag = 11'h007;
    tick();
    bus.mem_flush = 1'b0;
    chk("cmo_arvalid", bus.axi_arvalid, 0);
    chk("cmo_awvalid", bus.axi_awvalid, 0);
    chk("cmo_wvalid",  bus.axi_wvalid,  0);
    chk("cmo_ack0",    bus.mem_ack,     0);
    tick();
    chk("cmo_ack",    bus.mem_ack,      1);
    chk("cmo_err",    bus.mem_error,    0);
    chk("cmo_tag",    bus.mem_resp_tag, 11'h007);
    chk("cmo_accept", bus.mem_accept,   1);
    bus.mem_invalidate = 1'b1;
    bus.mem_req_tag    = 11'h003;
    tick();
    bus.mem_invalidate = 1'b0;
    chk("b2b_ack0",   bus.mem_ack,    0);
    chk("b2b_accept", bus.mem_accept, 0);
    tick();
    chk("b2b_ack", bus.mem_ack,      1);
    chk("b2b_tag", bus.mem_resp_tag, 11'h003);
    tick();

    // read timeout after 8 RD_DATA cycles, then a late R beat is drained
    bus.mem_rd      = 1'b1;
    bus.mem_addr    = 32'h0000_1000;
    bus.mem_req_tag = 11'h0AB;
    tick();
    bus.mem_rd      = 1'b0;
    bus.axi_arready = 1'b1;
    tick();
    bus.axi_arready = 1'b0;
    chk("tmo_rready", bus.axi_rready, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("tmo_no_ack", bus.mem_ack, 0);
    end
    tick();
    chk("tmo_ack",    bus.mem_ack,      1);
    chk("tmo_err",    bus.mem_error,    1);
    chk("tmo_rdata",  bus.mem_rdata,    0);
    chk("tmo_tag",    bus.mem_resp_tag, 11'h0AB);
    chk("tmo_accept", bus.mem_accept,   0);
    chk("drn_rready", bus.axi_rready,   1);
    chk("drn_bready", bus.axi_bready,   1);
    tick();
    chk("drn_ack",    bus.mem_ack,    0);
    chk("drn_accept", bus.mem_accept, 0);
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = 32'h5555_5555;
    tick();
    bus.axi_rvalid = 1'b0;
    chk("drn_done_ack",    bus.mem_ack,    0);
    chk("drn_done_accept", bus.mem_accept, 1);
    chk("drn_done_rready", bus.axi_rready, 0);
    chk("drn_done_bready", bus.axi_bready, 0);
    tick();

    // asynchronous reset while AW/W are pending
    bus.mem_wr    = 4'b0001;
    bus.mem_addr  = 32'h0000_2000;
    bus.mem_wdata = 32'h0000_00FF;
    tick();
    bus.mem_wr = 4'b0000;
    chk("ar_awvalid_pre", bus.axi_awvalid, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_awvalid", bus.axi_awvalid, 0);
    chk("ar_wvalid",  bus.axi_wvalid,  0);
    chk("ar_ack",     bus.mem_ack,     0);
    #2 rst_n = 1'b0;
    tick();
    chk("ar_accept",      bus.mem_accept,  1);
    chk("ar_awvalid_rel", bus.axi_awvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
